dest_decode_scoreboard: RTL and testbench
=========================================

Name: dest_decode_scoreboard

Overview:
- Parametrised successor to the fixed 3-to-8 decoder used in the MIPS-32 datapath.
- Converts an ADDR_W-bit destination register address into a registered one-hot write-enable vector, with a valid/ready handshake.
- Also maintains a busy-bit scoreboard of in-flight destination writes, used by the issue stage for RAW/WAW hazard stalls.
- Sits between the decode/issue stage and the register file write port.

Parameters:
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable).
- ZERO_HARDWIRED, 1, when 1 register 0 never decodes to a write enable and is never marked busy.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dec_valid  input  1  decode request valid.
- dec_addr  input  ADDR_W  address to decode.
- dec_ready  output  1  block can accept a decode request this cycle.
- we_valid  output  1  registered one-hot result valid.
- we_onehot  output  NUM_REGS  registered one-hot write-enable; bit i set means register i.
- we_ready  input  1  downstream accepts we_onehot.
- issue_valid  input  1  instruction issue attempt with a destination write.
- issue_addr  input  ADDR_W  destination of the issuing instruction.
- rs_addr  input  ADDR_W  source operand 1 of the issuing instruction.
- rt_addr  input  ADDR_W  source operand 2 of the issuing instruction.
- wb_valid  input  1  writeback completing this cycle.
- wb_addr  input  ADDR_W  writeback destination.
- stall  output  1  issue must be held (combinational).
- busy_mask  output  NUM_REGS  current scoreboard (registered).
- pending_cnt  output  ADDR_W+1  population count of busy_mask (registered).

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - we_valid=0, we_onehot=0, busy_mask=0, pending_cnt=0.
  - dec_ready=1 in the cycle after reset.
  - Reset mid-operation discards any held decode result and all busy bits.
- Decode pipeline (1 register stage, latency 1):
  - dec_ready = !we_valid || we_ready.
  - Transfer occurs when dec_valid && dec_ready: next cycle we_valid=1 and we_onehot = 1 << dec_addr.
  - With ZERO_HARDWIRED=1 and dec_addr=0, we_onehot=0 but we_valid=1 (request still consumed).
  - If we_valid && !we_ready, we_onehot and we_valid hold stable; dec_ready=0.
  - If we_ready && !(dec_valid && dec_ready), we_valid falls to 0 next cycle; we_onehot keeps its last value.
  - Back-to-back accepts sustain one result per cycle.
- Scoreboard:
  - Effective busy for hazard checks: eff_busy[i] = busy_mask[i] && !(wb_valid && wb_addr==i), i.e. same-cycle writeback bypass.
  - stall = issue_valid && (eff_busy[rs_addr] || eff_busy[rt_addr] || eff_busy[issue_addr]).
  - issue_fire = issue_valid && !stall.
  - Each cycle: busy_mask_next = (busy_mask & ~wb_onehot) | issue_onehot.
    - wb_onehot = wb_valid ? 1<<wb_addr : 0.
    - issue_onehot = issue_fire ? 1<<issue_addr : 0.
    - Set wins over clear when both target the same index.
  - With ZERO_HARDWIRED=1, bit 0 is forced to 0 and never causes a stall.
  - wb to a non-busy register: no effect, no error.
  - pending_cnt = popcount(busy_mask_next), registered alongside busy_mask; max value NUM_REGS fits in ADDR_W+1 bits.
- The decode path and the scoreboard are independent; both may be active in the same cycle.

Test Plan:
- Reset then dec_valid=1, dec_addr=5, we_ready=1 -> cycle+1: we_valid=1, we_onehot=32'h0000_0020; dec_ready stays 1.
- dec_addr=0, ZERO_HARDWIRED=1 -> we_valid=1, we_onehot=0. Same with ZERO_HARDWIRED=0 -> we_onehot=32'h1.
- Accept addr 31, then hold we_ready=0 for 3 cycles -> we_onehot=32'h8000_0000 stable, dec_ready=0. Raise we_ready with dec_valid=1, addr 1 -> next cycle we_onehot=32'h2.
- Issue dest 7 (no hazards) -> busy_mask bit7=1, pending_cnt=1. Next cycle issue rs=7 -> stall=1. Same cycle wb_valid=1, wb_addr=7 -> stall=0 (bypass); bit7 set again by the new issue (set-wins), pending_cnt=1.
- Issue dest 3,4,5 on consecutive cycles, then issue dest 4 -> stall=1 (WAW), pending_cnt=3. Assert reset mid-sequence -> busy_mask=0, pending_cnt=0, stall=0 next cycle.
- Fill all 31 registers 1..31 (ZERO_HARDWIRED=1) -> pending_cnt=31. Issue dest 0 -> no stall, bit0 stays 0.

Source files
------------

// File: rtl/dest_decode_scoreboard.sv
// Destination register decoder with a registered one-hot write-enable output
// and a busy-bit scoreboard of in-flight destination writes for issue stalls.
module dest_decode_scoreboard #(
  parameter int unsigned ADDR_W         = 5,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dec_valid,
  input  logic [ADDR_W-1:0]       dec_addr,
  output logic                    dec_ready,
  output logic                    we_valid,
  output logic [(1<<ADDR_W)-1:0]  we_onehot,
  input  logic                    we_ready,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic [ADDR_W-1:0]       rs_addr,
  input  logic [ADDR_W-1:0]       rt_addr,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_addr,
  output logic                    stall,
  output logic [(1<<ADDR_W)-1:0]  busy_mask,
  output logic [ADDR_W:0]         pending_cnt
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  logic                dec_fire;
  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:0] wb_onehot;
  logic [NUM_REGS-1:0] issue_onehot;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [CNT_W-1:0]    cnt_next;

  // Output stage can take a new result when empty or being drained this cycle
  always_comb begin
    dec_ready  = !we_valid || we_ready;
    dec_fire   = dec_valid && dec_ready;
    dec_onehot = NUM_REGS'(1) << dec_addr;
    if (ZERO_HARDWIRED) dec_onehot[0] = 1'b0;
  end

  // Decode result register; onehot keeps its last value once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      we_valid  <= 1'b0;
      we_onehot <= '0;
    end else if (dec_fire) begin
      we_valid  <= 1'b1;
      we_onehot <= dec_onehot;
    end else if (we_ready) begin
      we_valid  <= 1'b0;
    end
  end

  // Hazard detection with same-cycle writeback bypass and next scoreboard state
  always_comb begin
    wb_onehot    = '0;
    issue_onehot = '0;
    if (wb_valid) wb_onehot = NUM_REGS'(1) << wb_addr;
    eff_busy = busy_mask & ~wb_onehot;
    if (ZERO_HARDWIRED) eff_busy[0] = 1'b0;
    stall = issue_valid &&
            (eff_busy[rs_addr] || eff_busy[rt_addr] || eff_busy[issue_addr]);
    if (issue_valid && !stall) issue_onehot = NUM_REGS'(1) << issue_addr;
    // Set applied after clear so a same-index issue wins over writeback
    busy_next = (busy_mask & ~wb_onehot) | issue_onehot;
    if (ZERO_HARDWIRED) busy_next[0] = 1'b0;
  end

  // Population count of the next scoreboard so the count tracks busy_mask
  always_comb begin
    cnt_next = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
    end
  end

  // Scoreboard and pending count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask   <= '0;
      pending_cnt <= '0;
    end else begin
      busy_mask   <= busy_next;
      pending_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_dest_decode_scoreboard.sv
// Self-checking bench: two instances (register 0 hardwired and not) sharing
// stimulus, checked against constants and a behavioural reference model.
module tb_dest_decode_scoreboard;

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_addr;
  logic        we_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr, rs_addr, rt_addr;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  logic        dec_ready_z, we_valid_z, stall_z;
  logic [31:0] we_onehot_z, busy_mask_z;
  logic [5:0]  pending_cnt_z;
  logic        dec_ready_n, we_valid_n, stall_n;
  logic [31:0] we_onehot_n, busy_mask_n;
  logic [5:0]  pending_cnt_n;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          busy_z [32];
  bit          busy_n [32];
  bit          m_wv;
  logic [31:0] m_oh_z, m_oh_n;

  dest_decode_scoreboard #(.ADDR_W(5), .ZERO_HARDWIRED(1'b1)) dut_z (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_addr(dec_addr),
    .dec_ready(dec_ready_z), .we_valid(we_valid_z), .we_onehot(we_onehot_z),
    .we_ready(we_ready), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall(stall_z), .busy_mask(busy_mask_z), .pending_cnt(pending_cnt_z));

  dest_decode_scoreboard #(.ADDR_W(5), .ZERO_HARDWIRED(1'b0)) dut_n (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_addr(dec_addr),
    .dec_ready(dec_ready_n), .we_valid(we_valid_n), .we_onehot(we_onehot_n),
    .we_ready(we_ready), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall(stall_n), .busy_mask(busy_mask_n), .pending_cnt(pending_cnt_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_busy(bit zh, int a);
    return zh ? busy_z[a] : busy_n[a];
  endfunction

  // A register is a hazard if busy and not retiring this very cycle
  function automatic bit model_hazard(bit zh, int a);
    return model_busy(zh, a) && !(wb_valid && int'(wb_addr) == a);
  endfunction

  function automatic bit model_stall(bit zh);
    if (!issue_valid) return 1'b0;
    return model_hazard(zh, int'(rs_addr)) || model_hazard(zh, int'(rt_addr)) ||
           model_hazard(zh, int'(issue_addr));
  endfunction

  function automatic logic [31:0] model_mask(bit zh);
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = model_busy(zh, i);
    return m;
  endfunction

  function automatic int model_cnt(bit zh);
    int c = 0;
    for (int i = 0; i < 32; i++) c += model_busy(zh, i) ? 1 : 0;
    return c;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    bit sz, sn, dr;
    sz = model_stall(1'b1);
    sn = model_stall(1'b0);
    dr = !m_wv || we_ready;
    @(posedge clk);
    if (reset) begin
      m_wv = 1'b0; m_oh_z = '0; m_oh_n = '0;
      for (int i = 0; i < 32; i++) begin busy_z[i] = 1'b0; busy_n[i] = 1'b0; end
    end else begin
      if (dec_valid && dr) begin
        m_wv   = 1'b1;
        m_oh_n = 32'h1 << dec_addr;
        m_oh_z = (dec_addr == 5'd0) ? 32'h0 : m_oh_n;
      end else if (we_ready) begin
        m_wv = 1'b0;
      end
      if (wb_valid) begin busy_z[wb_addr] = 1'b0; busy_n[wb_addr] = 1'b0; end
      if (issue_valid && !sz && issue_addr != 5'd0) busy_z[issue_addr] = 1'b1;
      if (issue_valid && !sn) busy_n[issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_addr = 0; we_ready = 1; issue_valid = 0;
    issue_addr = 0; rs_addr = 0; rt_addr = 0; wb_valid = 0; wb_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; tick(); tick();
    reset = 0; #1;
    checks++; if (we_valid_z !== 1'b0) begin errors++; $display("FAIL reset_we_valid got %b exp 0", we_valid_z); end
    checks++; if (we_onehot_z !== 32'h0) begin errors++; $display("FAIL reset_we_onehot got %h exp 0", we_onehot_z); end
    checks++; if (busy_mask_z !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_mask_z); end
    checks++; if (pending_cnt_z !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", pending_cnt_z); end
    checks++; if (dec_ready_z !== 1'b1) begin errors++; $display("FAIL reset_dec_ready got %b exp 1", dec_ready_z); end
    checks++; if (stall_z !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_z); end
  endtask

  task automatic test_decode();
    dec_valid = 1; dec_addr = 5'd5; we_ready = 1;
    tick();
    checks++; if (we_valid_z !== 1'b1) begin errors++; $display("FAIL dec5_valid got %b exp 1", we_valid_z); end
    checks++; if (we_onehot_z !== 32'h0000_0020) begin errors++; $display("FAIL dec5_onehot got %h exp 00000020", we_onehot_z); end
    checks++; if (dec_ready_z !== 1'b1) begin errors++; $display("FAIL dec5_ready got %b exp 1", dec_ready_z); end
    dec_addr = 5'd0;
    tick();
    checks++; if (we_valid_z !== 1'b1) begin errors++; $display("FAIL dec0_valid got %b exp 1", we_valid_z); end
    checks++; if (we_onehot_z !== 32'h0) begin errors++; $display("FAIL dec0_zh_onehot got %h exp 0", we_onehot_z); end
    checks++; if (we_onehot_n !== 32'h1) begin errors++; $display("FAIL dec0_nzh_onehot got %h exp 1", we_onehot_n); end
    dec_valid = 0;
    tick();
    checks++; if (we_valid_z !== 1'b0) begin errors++; $display("FAIL dec_drain_valid got %b exp 0", we_valid_z); end
  endtask

  task automatic test_backpressure();
    dec_valid = 1; dec_addr = 5'd31; we_ready = 1;
    tick();
    dec_valid = 0; we_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (we_onehot_z !== 32'h8000_0000) begin errors++; $display("FAIL hold_onehot cyc %0d got %h exp 80000000", k, we_onehot_z); end
      checks++; if (we_valid_z !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b exp 1", k, we_valid_z); end
      checks++; if (dec_ready_z !== 1'b0) begin errors++; $display("FAIL hold_ready cyc %0d got %b exp 0", k, dec_ready_z); end
    end
    we_ready = 1; dec_valid = 1; dec_addr = 5'd1; #1;
    checks++; if (dec_ready_z !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", dec_ready_z); end
    tick();
    checks++; if (we_onehot_z !== 32'h2) begin errors++; $display("FAIL release_onehot got %h exp 2", we_onehot_z); end
    dec_valid = 0;
    tick();
    checks++; if (we_valid_z !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", we_valid_z); end
    checks++; if (we_onehot_z !== 32'h2) begin errors++; $display("FAIL drain_keep got %h exp 2", we_onehot_z); end
  endtask

  task automatic test_bypass();
    issue_valid = 1; issue_addr = 5'd7; rs_addr = 0; rt_addr = 0; #1;
    checks++; if (stall_z !== 1'b0) begin errors++; $display("FAIL issue7_stall got %b exp 0", stall_z); end
    tick();
    checks++; if (busy_mask_z !== 32'h80) begin errors++; $display("FAIL issue7_busy got %h exp 80", busy_mask_z); end
    checks++; if (pending_cnt_z !== 6'd1) begin errors++; $display("FAIL issue7_cnt got %0d exp 1", pending_cnt_z); end
    rs_addr = 5'd7; #1;
    checks++; if (stall_z !== 1'b1) begin errors++; $display("FAIL raw_stall got %b exp 1", stall_z); end
    wb_valid = 1; wb_addr = 5'd7; #1;
    checks++; if (stall_z !== 1'b0) begin errors++; $display("FAIL bypass_stall got %b exp 0", stall_z); end
    tick();
    checks++; if (busy_mask_z !== 32'h80) begin errors++; $display("FAIL setwins_busy got %h exp 80", busy_mask_z); end
    checks++; if (pending_cnt_z !== 6'd1) begin errors++; $display("FAIL setwins_cnt got %0d exp 1", pending_cnt_z); end
    issue_valid = 0; rs_addr = 0;
    tick();
    checks++; if (pending_cnt_z !== 6'd0) begin errors++; $display("FAIL wb_clear_cnt got %0d exp 0", pending_cnt_z); end
    wb_valid = 0;
  endtask

  task automatic test_waw_reset();
    issue_valid = 1; rs_addr = 0; rt_addr = 0;
    for (int a = 3; a <= 5; a++) begin issue_addr = 5'(a); tick(); end
    issue_addr = 5'd4; #1;
    checks++; if (stall_z !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", stall_z); end
    checks++; if (pending_cnt_z !== 6'd3) begin errors++; $display("FAIL waw_cnt got %0d exp 3", pending_cnt_z); end
    reset = 1; tick();
    reset = 0; #1;
    checks++; if (busy_mask_z !== 32'h0) begin errors++; $display("FAIL rst_mid_busy got %h exp 0", busy_mask_z); end
    checks++; if (pending_cnt_z !== 6'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", pending_cnt_z); end
    checks++; if (stall_z !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", stall_z); end
    issue_valid = 0;
  endtask

  task automatic test_fill();
    issue_valid = 1; rs_addr = 0; rt_addr = 0;
    for (int a = 1; a < 32; a++) begin issue_addr = 5'(a); tick(); end
    checks++; if (pending_cnt_z !== 6'd31) begin errors++; $display("FAIL fill_cnt got %0d exp 31", pending_cnt_z); end
    issue_addr = 5'd0; #1;
    checks++; if (stall_z !== 1'b0) begin errors++; $display("FAIL fill_r0_stall got %b exp 0", stall_z); end
    tick();
    checks++; if (busy_mask_z !== 32'hFFFF_FFFE) begin errors++; $display("FAIL fill_r0_busy got %h exp fffffffe", busy_mask_z); end
    checks++; if (pending_cnt_z !== 6'd31) begin errors++; $display("FAIL fill_r0_cnt got %0d exp 31", pending_cnt_z); end
    checks++; if (pending_cnt_n !== 6'd32) begin errors++; $display("FAIL fill_full_cnt got %0d exp 32", pending_cnt_n); end
    issue_valid = 0;
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) < 2);
      dec_valid   = $urandom_range(0, 1);
      dec_addr    = 5'($urandom);
      we_ready    = ($urandom_range(0, 3) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_addr  = 5'($urandom);
      rs_addr     = 5'($urandom);
      rt_addr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_valid    = $urandom_range(0, 1);
      wb_addr     = 5'($urandom);
      #1;
      checks++; if (dec_ready_z !== (!m_wv || we_ready)) begin errors++; $display("FAIL rnd_dec_ready c%0d got %b", c, dec_ready_z); end
      checks++; if (stall_z !== model_stall(1'b1)) begin errors++; $display("FAIL rnd_stall_z c%0d got %b exp %b", c, stall_z, model_stall(1'b1)); end
      checks++; if (stall_n !== model_stall(1'b0)) begin errors++; $display("FAIL rnd_stall_n c%0d got %b exp %b", c, stall_n, model_stall(1'b0)); end
      tick();
      checks++; if (we_valid_z !== m_wv) begin errors++; $display("FAIL rnd_we_valid c%0d got %b exp %b", c, we_valid_z, m_wv); end
      checks++; if (we_onehot_z !== m_oh_z) begin errors++; $display("FAIL rnd_onehot_z c%0d got %h exp %h", c, we_onehot_z, m_oh_z); end
      checks++; if (we_onehot_n !== m_oh_n) begin errors++; $display("FAIL rnd_onehot_n c%0d got %h exp %h", c, we_onehot_n, m_oh_n); end
      checks++; if (busy_mask_z !== model_mask(1'b1)) begin errors++; $display("FAIL rnd_busy_z c%0d got %h exp %h", c, busy_mask_z, model_mask(1'b1)); end
      checks++; if (busy_mask_n !== model_mask(1'b0)) begin errors++; $display("FAIL rnd_busy_n c%0d got %h exp %h", c, busy_mask_n, model_mask(1'b0)); end
      checks++; if (int'(pending_cnt_z) != model_cnt(1'b1)) begin errors++; $display("FAIL rnd_cnt_z c%0d got %0d exp %0d", c, pending_cnt_z, model_cnt(1'b1)); end
      checks++; if (int'(pending_cnt_n) != model_cnt(1'b0)) begin errors++; $display("FAIL rnd_cnt_n c%0d got %0d exp %0d", c, pending_cnt_n, model_cnt(1'b0)); end
    end
    reset = 0;
  endtask

  initial begin
    m_wv = 1'b0; m_oh_z = '0; m_oh_n = '0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_decode();
    test_backpressure();
    test_bypass();
    test_waw_reset();
    test_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
